if_id_reg: RTL and testbench

IF_ID_REG -- requirements
Module: if_id_reg

---
 rtl/scpu_pipe_pkg.sv | 30 +++
 rtl/if_id_skid_buf.sv | 49 ++++
 rtl/if_id_reg.sv | 143 ++++++++++++++
 tb/tb_if_id_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/scpu_pipe_pkg.sv
// ============================================================================
// Module      : scpu_pipe_pkg
// Description : Shared pipeline constants and types for the IF/ID boundary.
//               Holds the canonical NOP (ADDI x0,x0,0), the reset PC, and the
//               IF/ID occupancy state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scpu_pipe_pkg;

    // ADDI x0, x0, 0 - what ID sees whenever it holds no real instruction
    localparam logic [31:0] C_NOP_INST = 32'h00000013;
    localparam logic [31:0] C_RESET_PC = 32'h00000000;

    // Occupancy of the IF/ID boundary
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // ID invalid, skid empty
        ST_FULL  = 2'd1,   // ID valid, skid empty
        ST_SKID  = 2'd2    // skid entry occupied
    } ifid_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_skid_buf.sv
// ============================================================================
// Module      : if_id_skid_buf
// Description : Single-entry skid storage for the IF/ID register. Captures a
//               fetch offer that arrives while ID is stalled. Clear wins over
//               load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_skid_buf
    import scpu_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    // Skid entry: clear drops the entry, load captures a new one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= C_RESET_PC;
            inst_q  <= C_NOP_INST;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with a one-entry skid buffer so a
//               fetch offer accepted during an ID stall is never lost.
//               Per-cycle priority: flush > stall > advance.
//               Optional macro IF_ID_PERF_CNT_EN adds saturating stall and
//               flush cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import scpu_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifidin_if_pc,
    input  logic [31:0] ifidin_if_inst,
    input  logic        ifidin_if_valid,
    output logic        ifidout_if_ready,
    input  logic        ifidin_stall,
    input  logic        ifidin_flush,
    output logic [31:0] ifidout_id_pc,
    output logic [31:0] ifidout_id_pc_plus4,
    output logic [31:0] ifidout_id_inst_orig,
    output logic        ifidout_id_valid
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] ifidout_stall_cnt,
    output logic [31:0] ifidout_flush_cnt
`endif
);

    logic [31:0] id_pc_q,   id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    ifid_state_e state_q,   state_d;

    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_valid;
    logic        skid_load;
    logic        skid_clear;
    logic        transfer;

    // Fetch can hand over whenever the skid slot is free
    assign ifidout_if_ready = !skid_valid;
    assign transfer         = ifidin_if_valid && !skid_valid;

    // Skid capture only during a stall; drained on advance, dropped on flush
    assign skid_load  = !ifidin_flush && ifidin_stall && transfer;
    assign skid_clear = ifidin_flush || (!ifidin_stall && skid_valid);

    if_id_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (ifidin_if_pc),
        .inst_i  (ifidin_if_inst),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst),
        .valid_o (skid_valid)
    );

    // Next ID contents and occupancy state, flush > stall > advance
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        state_d    = state_q;
        if (ifidin_flush) begin
            // PC is kept so downstream PC-relative logic sees a stable value
            id_inst_d  = C_NOP_INST;
            id_valid_d = 1'b0;
            state_d    = ST_EMPTY;
        end else if (ifidin_stall) begin
            if (transfer) begin
                state_d = ST_SKID;
            end
        end else if (skid_valid) begin
            id_pc_d    = skid_pc;
            id_inst_d  = skid_inst;
            id_valid_d = 1'b1;
            state_d    = ST_FULL;
        end else if (transfer) begin
            id_pc_d    = ifidin_if_pc;
            id_inst_d  = ifidin_if_inst;
            id_valid_d = 1'b1;
            state_d    = ST_FULL;
        end else begin
            id_inst_d  = C_NOP_INST;
            id_valid_d = 1'b0;
            state_d    = ST_EMPTY;
        end
    end

    // Main ID register and occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q    <= C_RESET_PC;
            id_inst_q  <= C_NOP_INST;
            id_valid_q <= 1'b0;
            state_q    <= ST_EMPTY;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            state_q    <= state_d;
        end
    end

    assign ifidout_id_pc        = id_pc_q;
    assign ifidout_id_pc_plus4  = id_pc_q + 32'd4;
    assign ifidout_id_inst_orig = id_inst_q;
    assign ifidout_id_valid     = id_valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counts of stalled cycles (flush excluded) and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (ifidin_stall && !ifidin_flush) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (ifidin_flush) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign ifidout_stall_cnt = stall_cnt_q;
    assign ifidout_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_reg.sv
// ============================================================================
// Module      : tb_if_id_reg
// Description : Scoreboard bench for if_id_reg. Stimulus pushes the expected
//               post-edge view into a queue; a monitor pops and compares one
//               entry after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_inst = 32'd0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_id_reg dut (
        .clk                  (clk),
        .rst                  (rst),
        .ifidin_if_pc         (if_pc),
        .ifidin_if_inst       (if_inst),
        .ifidin_if_valid      (if_valid),
        .ifidout_if_ready     (if_ready),
        .ifidin_stall         (stall),
        .ifidin_flush         (flush),
        .ifidout_id_pc        (id_pc),
        .ifidout_id_pc_plus4  (id_pc_plus4),
        .ifidout_id_inst_orig (id_inst),
        .ifidout_id_valid     (id_valid)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .ifidout_stall_cnt    (stall_cnt),
        .ifidout_flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        ready;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: what ID shows, plus a queue of at most one waiting entry
    logic [31:0] m_pc, m_inst;
    logic        m_valid;
    logic [31:0] w_pc[$];
    logic [31:0] w_inst[$];
    logic [31:0] m_scnt, m_fcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_inst = NOP; m_valid = 1'b0;
        w_pc.delete(); w_inst.delete();
        m_scnt = 32'd0; m_fcnt = 32'd0;
    endtask

    // One cycle: drive at negedge, advance the model, queue the expectation
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
        exp_t e;
        bit   can_take;
        @(negedge clk);
        if_valid = v; if_pc = pc; if_inst = inst; stall = st; flush = fl;
        can_take = (w_pc.size() == 0);
        if (fl) begin
            m_inst = NOP; m_valid = 1'b0;
            w_pc.delete(); w_inst.delete();
            if (m_fcnt != 32'hFFFFFFFF) m_fcnt = m_fcnt + 1;
        end else begin
            if (st) begin
                if (v && can_take) begin
                    w_pc.push_back(pc); w_inst.push_back(inst);
                end
                if (m_scnt != 32'hFFFFFFFF) m_scnt = m_scnt + 1;
            end else if (w_pc.size() != 0) begin
                m_pc = w_pc.pop_front(); m_inst = w_inst.pop_front(); m_valid = 1'b1;
            end else if (v) begin
                m_pc = pc; m_inst = inst; m_valid = 1'b1;
            end else begin
                m_inst = NOP; m_valid = 1'b0;
            end
        end
        e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.inst = m_inst; e.valid = m_valid;
        e.ready = (w_pc.size() == 0); e.scnt = m_scnt; e.fcnt = m_fcnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT against the oldest expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("id_pc",    id_pc,       e.pc);
                chk("pc_plus4", id_pc_plus4, e.pc4);
                chk("id_inst",  id_inst,     e.inst);
                chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
                chk("if_ready", {31'd0, if_ready}, {31'd0, e.ready});
`ifdef IF_ID_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, e.scnt);
                chk("flush_cnt", flush_cnt, e.fcnt);
`endif
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // Reset state while still in reset
        chk("rst_id_pc",    id_pc, 32'd0);
        chk("rst_id_inst",  id_inst, NOP);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_ready",    {31'd0, if_ready}, 32'd1);
        rst = 1'b0;

        // Back-to-back offers 0x0/0x4/0x8
        cyc(1, 32'h0, 32'h00100093, 0, 0);
        cyc(1, 32'h4, 32'h00200113, 0, 0);
        cyc(1, 32'h8, 32'h00300193, 0, 0);
        // 0x10 accepted, stall while 0x14 offered, then release
        cyc(1, 32'h10, 32'h00400213, 0, 0);
        cyc(1, 32'h14, 32'h00500293, 1, 0);
        cyc(0, 32'h0,  32'h0,        0, 0);
        cyc(0, 32'h0,  32'h0,        0, 0);
        // Build SKID then flush it
        cyc(1, 32'h20, 32'h00600313, 0, 0);
        cyc(1, 32'h24, 32'h00700393, 1, 0);
        cyc(1, 32'h28, 32'h00800413, 1, 0);
        cyc(1, 32'h2C, 32'h00900493, 0, 1);
        // Stall and flush together
        cyc(1, 32'h30, 32'h00A00513, 0, 0);
        cyc(1, 32'h34, 32'h00B00593, 1, 1);
        // PC wrap boundary
        cyc(1, 32'hFFFFFFFC, 32'h00C00613, 0, 0);
        cyc(0, 32'h0, 32'h0, 1, 0);

        // Async reset during SKID: outputs must clear without a clock edge
        cyc(1, 32'h40, 32'h00D00693, 0, 0);
        cyc(1, 32'h44, 32'h00E00713, 1, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_id_pc",    id_pc, 32'd0);
        chk("arst_id_inst",  id_inst, NOP);
        chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_ready",    {31'd0, if_ready}, 32'd1);
        model_reset();
        if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // First cycle after release behaves as EMPTY
        cyc(1, 32'h80, 32'h00F00793, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                $urandom & 32'hFFFFFFFC,
                $urandom,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 11) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
